// File: rtl/qbert_jump_sequencer.sv
// Qbert sprite jump sequencer: latches a start/target cube on iStart and steps the sprite
// once per LCD frame along a linear path with a parabolic lift. Define QBERT_JUMP_QUEUE_EN to hold one pending request.
module qbert_jump_sequencer #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int STEPS = 16,
    parameter int LIFT  = 32
) (
    input  logic           iCLK,
    input  logic           iRST_n,
    input  logic           iNewFrame,
    input  logic           iStart,
    input  logic [X_W-1:0] iX0,
    input  logic [Y_W-1:0] iY0,
    input  logic [X_W-1:0] iX1,
    input  logic [Y_W-1:0] iY1,
    output logic [X_W-1:0] oX,
    output logic [Y_W-1:0] oY,
    output logic [6:0]     oStep,
    output logic           oBusy,
    output logic           oDone
);

    localparam int LOG2 = $clog2(STEPS);
    localparam int PXW  = X_W + 9;
    localparam int PYW  = Y_W + 9;
    localparam int KKW  = 13;
    localparam logic signed [31:0] X_MAX = 32'((1 << X_W) - 1);
    localparam logic signed [31:0] Y_MAX = 32'((1 << Y_W) - 1);
    localparam logic [6:0]         K_LAST = 7'(STEPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MOVE  = 2'd2,
        S_LAND  = 2'd3
    } state_t;

    state_t                state_q;
    logic [X_W-1:0]        x0_q;
    logic [X_W-1:0]        x1_q;
    logic [Y_W-1:0]        y0_q;
    logic [Y_W-1:0]        y1_q;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic [6:0]            k_q;
    logic [6:0]            k_next;
    logic signed [PXW-1:0] prod_x_q;
    logic signed [PXW-1:0] prod_x_d;
    logic signed [PYW-1:0] prod_y_q;
    logic signed [PYW-1:0] prod_y_d;
    logic [KKW-1:0]        kk_q;
    logic [KKW-1:0]        kk_d;
    logic                  upd_q;
    logic                  busy_q;
    logic                  done_q;

    logic signed [X_W:0]   dx_w;
    logic signed [Y_W:0]   dy_w;
    logic signed [31:0]    x_sum;
    logic signed [31:0]    y_sum;
    logic [31:0]           lift_u;
    logic [X_W-1:0]        x_clamp;
    logic [Y_W-1:0]        y_clamp;

`ifdef QBERT_JUMP_QUEUE_EN
    logic                  q_vld_q;
    logic [X_W-1:0]        q_x0_q;
    logic [X_W-1:0]        q_x1_q;
    logic [Y_W-1:0]        q_y0_q;
    logic [Y_W-1:0]        q_y1_q;
`endif

    // iStart is a one-cycle request with no ready: it is taken in IDLE, otherwise it is
    // dropped (or parked in the one-entry queue when that is built in).

    // Stage 1 (on the frame pulse): next step index and the signed products for it.
    assign k_next   = (state_q == S_ARMED) ? 7'd1 : k_q + 7'd1;
    assign dx_w     = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
    assign dy_w     = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
    assign prod_x_d = PXW'(dx_w) * PXW'($signed({1'b0, k_next}));
    assign prod_y_d = PYW'(dy_w) * PYW'($signed({1'b0, k_next}));
    assign kk_d     = KKW'(k_next) * (KKW'(STEPS) - KKW'(k_next));

    // Stage 2: arithmetic shifts floor toward -inf, so negative moves round down.
    assign lift_u = (32'(LIFT) * 32'd4 * 32'(kk_q)) >> (2 * LOG2);
    assign x_sum  = 32'($signed({1'b0, x0_q})) + 32'(prod_x_q >>> LOG2);
    assign y_sum  = 32'($signed({1'b0, y0_q})) + 32'(prod_y_q >>> LOG2) - $signed(lift_u);

    always_comb begin
        x_clamp = x_sum[X_W-1:0];
        y_clamp = y_sum[Y_W-1:0];
        if (x_sum < 0) begin
            x_clamp = '0;
        end else if (x_sum > X_MAX) begin
            x_clamp = '1;
        end
        if (y_sum < 0) begin
            y_clamp = '0;
        end else if (y_sum > Y_MAX) begin
            y_clamp = '1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            x1_q     <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            prod_x_q <= '0;
            prod_y_q <= '0;
            kk_q     <= '0;
            upd_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef QBERT_JUMP_QUEUE_EN
            q_vld_q  <= 1'b0;
            q_x0_q   <= '0;
            q_x1_q   <= '0;
            q_y0_q   <= '0;
            q_y1_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            upd_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    x_q <= iX0;
                    y_q <= iY0;
                    if (iStart) begin
                        x0_q    <= iX0;
                        y0_q    <= iY0;
                        x1_q    <= iX1;
                        y1_q    <= iY1;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED, S_MOVE: begin
                    if (upd_q) begin
                        x_q <= x_clamp;
                        y_q <= y_clamp;
                    end
                    if (iNewFrame) begin
                        k_q      <= k_next;
                        prod_x_q <= prod_x_d;
                        prod_y_q <= prod_y_d;
                        kk_q     <= kk_d;
                        upd_q    <= 1'b1;
                        state_q  <= (k_next == K_LAST) ? S_LAND : S_MOVE;
                    end
                end
                S_LAND: begin
                    // The landing point is forced to the latched target, not recomputed.
                    x_q    <= x1_q;
                    y_q    <= y1_q;
                    done_q <= 1'b1;
`ifdef QBERT_JUMP_QUEUE_EN
                    if (iStart) begin
                        x0_q    <= iX0;
                        y0_q    <= iY0;
                        x1_q    <= iX1;
                        y1_q    <= iY1;
                        k_q     <= '0;
                        q_vld_q <= 1'b0;
                        state_q <= S_ARMED;
                    end else if (q_vld_q) begin
                        x0_q    <= q_x0_q;
                        y0_q    <= q_y0_q;
                        x1_q    <= q_x1_q;
                        y1_q    <= q_y1_q;
                        k_q     <= '0;
                        q_vld_q <= 1'b0;
                        state_q <= S_ARMED;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef QBERT_JUMP_QUEUE_EN
            if (iStart && (state_q == S_ARMED || state_q == S_MOVE)) begin
                q_vld_q <= 1'b1;
                q_x0_q  <= iX0;
                q_y0_q  <= iY0;
                q_x1_q  <= iX1;
                q_y1_q  <= iY1;
            end
`endif
        end
    end

    assign oX    = x_q;
    assign oY    = y_q;
    assign oStep = k_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule
